fetch_queue: RTL and testbench

Instruction queue between the fetch stage (PC register, PC+4 adder, instruction memory) and the decode stage. Captures each fetched {PC, instruction} pair under a valid/ready handshake and buffers up to DEPTH entries, so a decode stall does not lose fetched words. Presents entries to decode in program order. Discards all buffered entries in one cycle when the branch/jump redirect (PCSrc) fires.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fq_storage.sv | 39 +++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- shown to decode whenever no entry is available
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  // One buffered fetch result; misaligned is captured at push time
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid may not depend on ready, and ready is a function of registered
// state only, so neither side sees a combinational loop through the other.
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            f_valid;
  logic            f_ready;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_instr;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc_plus4;
  logic [XLEN-1:0] d_instr;
  logic            d_misaligned;
  logic [CW-1:0]   count;

  // Master drives fetch offers, decode ready and redirect
  modport master (
    output flush, f_valid, f_pc, f_instr, d_ready,
    input  f_ready, d_valid, d_pc, d_pc_plus4, d_instr, d_misaligned, count
  );

  // Slave is the queue itself
  modport slave (
    input  flush, f_valid, f_pc, f_instr, d_ready,
    output f_ready, d_valid, d_pc, d_pc_plus4, d_instr, d_misaligned, count
  );
endinterface

// File: rtl/fq_storage.sv
// DEPTH x fq_entry_t register array: one write port, one asynchronous read port.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  // Next-state of the array: only the addressed slot changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Array registers; cleared on reset so the read port shows zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: in-order circular buffer of
// {pc, instr, misaligned} with a single-cycle flush on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic      push;
  logic      pop;
  logic      wr_en;
  fq_entry_t wr_entry;
  fq_entry_t head;

  // Handshakes: ready looks only at registered occupancy, so a full queue
  // refuses a push even if decode pops in the same cycle
  assign bus.f_ready = (count_q < DEPTH_C) && !rst;
  assign bus.d_valid = (count_q != '0);
  assign push        = bus.f_valid && bus.f_ready;
  assign pop         = bus.d_valid && bus.d_ready;
  assign wr_en       = push && !bus.flush;

  // Entry captured from fetch; alignment flag is decided here, acted on in decode
  always_comb begin
    wr_entry            = '0;
    wr_entry.pc         = bus.f_pc;
    wr_entry.instr      = bus.f_instr;
    wr_entry.misaligned = (bus.f_pc[1:0] != 2'b00);
  end

  // Pointer and occupancy update; flush wins over both push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Decode-side view of the head slot; instr and flag are masked when empty
  assign bus.d_pc         = head.pc;
  assign bus.d_pc_plus4   = head.pc + XLEN'(4);
  assign bus.d_instr      = bus.d_valid ? head.instr : NOP_INSTR;
  assign bus.d_misaligned = bus.d_valid && head.misaligned;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 64;   // {instr, pc}

  logic clk;
  logic rst;

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;
  logic         last_accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every decode-side output against the model queue
  task automatic check_outputs();
    logic [31:0] hpc;
    logic [31:0] hins;
    logic [31:0] hplus4;
    check("d_valid", 64'(bus.d_valid), 64'(exp_q.size() != 0));
    check("count", 64'(bus.count), 64'(exp_q.size()));
    check("f_ready", 64'(bus.f_ready), 64'(exp_q.size() < DEPTH));
    if (exp_q.size() != 0) begin
      hpc    = exp_q[0][31:0];
      hins   = exp_q[0][63:32];
      hplus4 = hpc + 32'd4;
      check("d_pc", 64'(bus.d_pc), 64'(hpc));
      check("d_pc_plus4", 64'(bus.d_pc_plus4), 64'(hplus4));
      check("d_instr", 64'(bus.d_instr), 64'(hins));
      check("d_misaligned", 64'(bus.d_misaligned), 64'(hpc[1:0] != 2'b00));
    end else begin
      check("d_instr_empty", 64'(bus.d_instr), 64'(NOP_INSTR));
      check("d_mis_empty", 64'(bus.d_misaligned), 64'd0);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, apply the queue rules to the model at the edge,
  // then compare just after the edge.
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic dr, input logic fl);
    bus.f_valid = fv;
    bus.f_pc    = pc;
    bus.f_instr = ins;
    bus.d_ready = dr;
    bus.flush   = fl;
    @(posedge clk);
    last_accepted = fv && (exp_q.size() < DEPTH);
    if (fl) begin
      exp_q.delete();
      last_accepted = 1'b0;
    end else begin
      if (dr && exp_q.size() != 0) void'(exp_q.pop_front());
      if (last_accepted) exp_q.push_back({ins, pc});
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.f_valid = 1'b0;
    bus.f_pc    = '0;
    bus.f_instr = '0;
    bus.d_ready = 1'b0;
    bus.flush   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pend_pc;
    logic [31:0] pend_ins;
    logic        have_pend;
    int          guard;

    idle_inputs();
    rst = 1'b1;
    #2;
    check("rst_d_valid", 64'(bus.d_valid), 64'd0);
    check("rst_d_instr", 64'(bus.d_instr), 64'h13);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_f_ready", 64'(bus.f_ready), 64'd0);
    check("rst_d_pc", 64'(bus.d_pc), 64'd0);
    check("rst_d_pc_plus4", 64'(bus.d_pc_plus4), 64'd4);
    check("rst_d_mis", 64'(bus.d_misaligned), 64'd0);
    #20;
    rst = 1'b0;
    #1;
    check("release_f_ready", 64'(bus.f_ready), 64'd1);

    // Stream with decode always ready
    cycle(1'b1, 32'h0, 32'h00500093, 1'b1, 1'b0);
    check("stream_cnt_le1_a", 64'(bus.count <= 1), 64'd1);
    cycle(1'b1, 32'h4, 32'h00a00113, 1'b1, 1'b0);
    check("stream_cnt_le1_b", 64'(bus.count <= 1), 64'd1);
    cycle(1'b1, 32'h8, 32'h002081b3, 1'b1, 1'b0);
    check("stream_cnt_le1_c", 64'(bus.count <= 1), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill with decode stalled, then hold a 5th offer until it gets in
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0);
    check("full_count", 64'(bus.count), 64'd4);
    check("full_f_ready", 64'(bus.f_ready), 64'd0);
    cycle(1'b1, 32'h110, 32'hA004, 1'b0, 1'b0);
    check("held_5th", 64'(last_accepted), 64'd0);
    cycle(1'b1, 32'h110, 32'hA004, 1'b1, 1'b0);
    check("full_pop_no_push", 64'(last_accepted), 64'd0);
    cycle(1'b1, 32'h110, 32'hA004, 1'b1, 1'b0);
    check("5th_after_pop", 64'(last_accepted), 64'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Push and pop together at count 2
    cycle(1'b1, 32'h200, 32'hB000, 1'b0, 1'b0);
    cycle(1'b1, 32'h204, 32'hB001, 1'b0, 1'b0);
    cycle(1'b1, 32'h208, 32'hB002, 1'b1, 1'b0);
    check("pushpop_count", 64'(bus.count), 64'd2);
    cycle(1'b1, 32'h20c, 32'hB003, 1'b1, 1'b0);
    check("pushpop_head", 64'(bus.d_pc), 64'h208);

    // Flush at count 3 with an offer in the same cycle
    cycle(1'b1, 32'h210, 32'hB004, 1'b0, 1'b0);
    cycle(1'b1, 32'h1000, 32'hC000, 1'b1, 1'b1);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_d_valid", 64'(bus.d_valid), 64'd0);
    check("flush_f_ready", 64'(bus.f_ready), 64'd1);
    cycle(1'b1, 32'h1000, 32'hC000, 1'b0, 1'b0);
    check("post_flush_head", 64'(bus.d_pc), 64'h1000);

    // Edge values
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFFFFFFC, 32'hD000, 1'b0, 1'b0);
    check("pc_plus4_wrap", 64'(bus.d_pc_plus4), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h6, 32'hD001, 1'b0, 1'b0);
    check("misaligned_flag", 64'(bus.d_misaligned), 64'd1);

    // Asynchronous reset with two entries queued
    cycle(1'b1, 32'h300, 32'hE000, 1'b0, 1'b0);
    check("pre_rst_count", 64'(bus.count), 64'd2);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_d_valid", 64'(bus.d_valid), 64'd0);
    check("async_rst_count", 64'(bus.count), 64'd0);
    check("async_rst_f_ready", 64'(bus.f_ready), 64'd0);
    check("async_rst_d_pc_plus4", 64'(bus.d_pc_plus4), 64'd4);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rerelease_f_ready", 64'(bus.f_ready), 64'd1);

    // Randomized traffic; fetch holds an offer until it is taken
    have_pend = 1'b0;
    pend_pc   = '0;
    pend_ins  = '0;
    guard     = 0;
    for (int i = 0; i < 600; i++) begin
      logic fv;
      logic dr;
      logic fl;
      if (!have_pend) begin
        pend_pc  = $urandom();
        if ($urandom_range(0, 7) != 0) pend_pc[1:0] = 2'b00;
        pend_ins = $urandom();
      end
      fv = have_pend || ($urandom_range(0, 3) != 0);
      dr = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      cycle(fv, pend_pc, pend_ins, dr, fl);
      have_pend = fv && !last_accepted && !fl;
      guard++;
    end
    check("random_cycles_done", 64'(guard), 64'd600);

    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "time limit");
  end

endmodule
